hazard_scoreboard: RTL
======================

# hazard_scoreboard

Parametrised load-use hazard and operand-forwarding unit for the decode stage of the RISC-V pipeline. It replaces the single "last instruction was a load" comparison with a per-register pending-load scoreboard that tracks up to `MAX_PENDING` outstanding loads. It merges `NUM_FW` priority-ordered forwarding sources plus the load write-back port, and raises a decode stall request on RAW, WAW or capacity hazards. It sits beside decode; decode's operand selection consumes its outputs, and the pipeline controller consumes `stall_req_o`.

## Interface
Parameters:
- `NUM_FW`, 2: number of ALU forwarding sources; index 0 is the youngest (EX) and has the highest priority.
- `MAX_PENDING`, 4: maximum outstanding loads; range 1..31.
- `DATA_W`, 32: register data width.
- `REG_AW`, 5: register address width; the register file has 2^REG_AW entries.
- `STALL_TIMEOUT`, 64: watchdog limit in cycles; only used with `SCOREBOARD_WATCHDOG_EN`.

Ports (`CW` = $clog2(MAX_PENDING+1)):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `issue_valid_i`  in  1  decode presents an instruction.
- `issue_is_load_i`  in  1  the presented instruction is a LOAD.
- `issue_rd_addr_i`  in  REG_AW  destination register.
- `rs1_read_enable_i`, `rs2_read_enable_i`  in  1 each  source operands used.
- `rs1_addr_i`, `rs2_addr_i`  in  REG_AW each  source addresses.
- `rs1_rf_data_i`, `rs2_rf_data_i`  in  DATA_W each  register-file read data.
- `fw_valid_i`  in  NUM_FW  per-source result-ready flags.
- `fw_addr_i`  in  NUM_FW*REG_AW  flattened destination addresses; source k occupies bits [k*REG_AW +: REG_AW].
- `fw_data_i`  in  NUM_FW*DATA_W  flattened result data, packed the same way.
- `flush_i`  in  1  pipeline flush (branch or jump redirect).
- `ld_wb_valid_i`  in  1  load data returning this cycle.
- `ld_wb_addr_i`  in  REG_AW  destination of the returning load.
- `ld_wb_data_i`  in  DATA_W  returning load data.
- `rs1_data_o`, `rs2_data_o`  out  DATA_W each  resolved operands.
- `stall_req_o`  out  1  hold decode and fetch.
- `pending_cnt_o`  out  CW  count of outstanding loads.
- `timeout_o`  out  1  sticky watchdog error (constant 0 without the macro).

## Operation
**State**
- `pending[2^REG_AW-1:0]` bitmap; bit 0 is hard-wired to 0.
- Outstanding-load counter `cnt`.

**Operand resolution** (combinational, evaluated per operand):
- Read enable low → output 0.
- Address 0 → output 0.
- Otherwise the first matching source wins:
  1. The lowest-index `fw` source with `fw_valid_i[k]` set and a matching address.
  2. The load write-back port, if `ld_wb_valid_i` is set and the address matches.
  3. The register-file data.

**Stall**: `stall_req_o` is the OR of three hazards:
- RAW: an operand is enabled, its address is nonzero, its pending bit is set, and the load write-back port is not returning that same register this cycle.
- WAW: `issue_valid_i & issue_is_load_i`, `rd` is nonzero, and `pending[rd]` is set with no same-cycle write-back to `rd`.
- Full: `issue_valid_i & issue_is_load_i`, `cnt == MAX_PENDING`, and `ld_wb_valid_i` is low.

**Accept**: `acc = issue_valid_i & issue_is_load_i & ~stall_req_o & ~flush_i & (rd != 0)`.

**Edge update**, in priority order:
1. `flush_i` → clear all pending bits and set `cnt` to 0. The pipeline guarantees that killed loads never write back.
2. Otherwise, `ld_wb_valid_i` clears `pending[ld_wb_addr_i]`, then `acc` sets `pending[rd]`. When both target the same register, the set wins.
3. `cnt` advances by `+acc - wb`. A write-back to a non-pending register does not change the bitmap. `cnt` saturates at 0 and never underflows.

A load to x0 is never tracked.

## Timing
- Operand outputs and `stall_req_o` are combinational, valid in the same cycle as their inputs.
- A scoreboard update becomes visible in the cycle after the accepting edge. An instruction that reads the rd of a load accepted at edge N stalls from cycle N+1.
- A stall releases in the cycle that `ld_wb_valid_i` returns the register; the operand is forwarded from `ld_wb_data_i` in that cycle.
- Reset (asynchronous, while `rst_n` is low): pending bitmap = 0, `cnt` = 0, `timeout_o` = 0, watchdog counter = 0.
  - `pending_cnt_o` = 0.
  - `stall_req_o` = 0 regardless of inputs.
- Reset asserted mid-operation drops all in-flight tracking immediately.
- `flush_i` in the same cycle as a hazard: `stall_req_o` still reflects the hazard combinationally, but no issue is accepted, and the next cycle starts with an empty scoreboard.

## Configuration
- `SCOREBOARD_WATCHDOG_EN` defined:
  - A counter increments on each cycle with `stall_req_o` high and clears on any cycle with it low.
  - When the counter reaches `STALL_TIMEOUT`, `timeout_o` sets and stays set until reset.
  - The counter saturates.
- Not defined: no counter logic is built, and `timeout_o` is tied to 0.

## Test plan
- **RAW stall and release:** issue a load to x5 (`acc`); next cycle present rs1 = x5 → `stall_req_o` = 1. Then drive `ld_wb_valid_i` with x5 and data 0xDEADBEEF → stall = 0 and `rs1_data_o` = 0xDEADBEEF in that cycle; x5 pending is clear afterwards.
- **Forwarding priority:** `fw[0]` and `fw[1]` both target x7 with data 0x11 and 0x22, and write-back targets x7 with 0x33 → `rs2_data_o` = 0x11. Drop `fw[0]` → 0x22. Drop `fw[1]` → 0x33. Read x0 → 0.
- **Capacity:** accept 4 loads to x1..x4, then a fifth load to x6 → `stall_req_o` = 1 and `pending_cnt_o` = 4. Same cycle with a write-back of x1 → no stall, and `cnt` stays at 4.
- **WAW and simultaneous update:** with x9 pending, a new load to x9 stalls. With x9 pending and a write-back of x9 in the same cycle, a new load to x9 is accepted and x9 is still pending next cycle.
- **Flush and reset:** with 3 loads pending, pulse `flush_i` → `pending_cnt_o` = 0 next cycle and no RAW stall. Assert `rst_n` low mid-stall → all outputs return to their reset values immediately.
- **Watchdog (macro on, `STALL_TIMEOUT` = 8):** hold a RAW hazard for 8 cycles → `timeout_o` = 1 and stays 1 after the stall clears. With the macro off, `timeout_o` = 0 throughout.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle for hazard_scoreboard: issue, operand, forwarding and load write-back signals.
// Master is decode/pipeline control, slave is the scoreboard; parameters must match the scoreboard's.
interface hazard_scoreboard_if #(
  parameter int NUM_FW      = 2,
  parameter int MAX_PENDING = 4,
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5
);
  localparam int CW = $clog2(MAX_PENDING + 1);

  logic                     issue_valid_i;
  logic                     issue_is_load_i;
  logic [REG_AW-1:0]        issue_rd_addr_i;
  logic                     rs1_read_enable_i;
  logic                     rs2_read_enable_i;
  logic [REG_AW-1:0]        rs1_addr_i;
  logic [REG_AW-1:0]        rs2_addr_i;
  logic [DATA_W-1:0]        rs1_rf_data_i;
  logic [DATA_W-1:0]        rs2_rf_data_i;
  logic [NUM_FW-1:0]        fw_valid_i;
  logic [NUM_FW*REG_AW-1:0] fw_addr_i;
  logic [NUM_FW*DATA_W-1:0] fw_data_i;
  logic                     flush_i;
  logic                     ld_wb_valid_i;
  logic [REG_AW-1:0]        ld_wb_addr_i;
  logic [DATA_W-1:0]        ld_wb_data_i;
  logic [DATA_W-1:0]        rs1_data_o;
  logic [DATA_W-1:0]        rs2_data_o;
  logic                     stall_req_o;
  logic [CW-1:0]            pending_cnt_o;
  logic                     timeout_o;

  modport master (
    output issue_valid_i, issue_is_load_i, issue_rd_addr_i,
           rs1_read_enable_i, rs2_read_enable_i, rs1_addr_i, rs2_addr_i,
           rs1_rf_data_i, rs2_rf_data_i, fw_valid_i, fw_addr_i, fw_data_i,
           flush_i, ld_wb_valid_i, ld_wb_addr_i, ld_wb_data_i,
    input  rs1_data_o, rs2_data_o, stall_req_o, pending_cnt_o, timeout_o
  );

  modport slave (
    input  issue_valid_i, issue_is_load_i, issue_rd_addr_i,
           rs1_read_enable_i, rs2_read_enable_i, rs1_addr_i, rs2_addr_i,
           rs1_rf_data_i, rs2_rf_data_i, fw_valid_i, fw_addr_i, fw_data_i,
           flush_i, ld_wb_valid_i, ld_wb_addr_i, ld_wb_data_i,
    output rs1_data_o, rs2_data_o, stall_req_o, pending_cnt_o, timeout_o
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register pending-load scoreboard with operand forwarding; outputs are combinational, tracking updates on the next edge.
// No backpressure of its own: hazards raise stall_req_o to hold decode. Optional stall watchdog: SCOREBOARD_WATCHDOG_EN.
module hazard_scoreboard #(
  parameter int NUM_FW        = 2,
  parameter int MAX_PENDING   = 4,
  parameter int DATA_W        = 32,
  parameter int REG_AW        = 5,
  parameter int STALL_TIMEOUT = 64
) (
  input logic                clk,
  input logic                rst_n,
  hazard_scoreboard_if.slave sb
);
  localparam int NREG = 1 << REG_AW;
  localparam int CW   = $clog2(MAX_PENDING + 1);

  logic [NREG-1:0] r_pending;
  logic [CW-1:0]   r_cnt;
  logic [NREG-1:0] w_pending_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_rs1_haz;
  logic            w_rs2_haz;
  logic            w_load;
  logic            w_waw;
  logic            w_full;
  logic            w_stall;
  logic            w_acc;

  // Lowest-index forwarding source wins, then load write-back, then register file.
  function automatic logic [DATA_W-1:0] f_resolve(
    input logic                     en,
    input logic [REG_AW-1:0]        addr,
    input logic [DATA_W-1:0]        rf,
    input logic [NUM_FW-1:0]        fv,
    input logic [NUM_FW*REG_AW-1:0] fa,
    input logic [NUM_FW*DATA_W-1:0] fd,
    input logic                     wv,
    input logic [REG_AW-1:0]        wa,
    input logic [DATA_W-1:0]        wd
  );
    logic [DATA_W-1:0] res;
    res = rf;
    if (wv && (wa == addr)) res = wd;
    for (int k = NUM_FW - 1; k >= 0; k--) begin
      if (fv[k] && (fa[k*REG_AW +: REG_AW] == addr)) res = fd[k*DATA_W +: DATA_W];
    end
    if (!en || (addr == '0)) res = '0;
    return res;
  endfunction

  assign sb.rs1_data_o = f_resolve(sb.rs1_read_enable_i, sb.rs1_addr_i, sb.rs1_rf_data_i,
                                   sb.fw_valid_i, sb.fw_addr_i, sb.fw_data_i,
                                   sb.ld_wb_valid_i, sb.ld_wb_addr_i, sb.ld_wb_data_i);
  assign sb.rs2_data_o = f_resolve(sb.rs2_read_enable_i, sb.rs2_addr_i, sb.rs2_rf_data_i,
                                   sb.fw_valid_i, sb.fw_addr_i, sb.fw_data_i,
                                   sb.ld_wb_valid_i, sb.ld_wb_addr_i, sb.ld_wb_data_i);

  // A register returning this cycle is no longer a hazard: it is forwarded from ld_wb_data_i.
  assign w_rs1_haz = sb.rs1_read_enable_i && (sb.rs1_addr_i != '0) && r_pending[sb.rs1_addr_i] &&
                     !(sb.ld_wb_valid_i && (sb.ld_wb_addr_i == sb.rs1_addr_i));
  assign w_rs2_haz = sb.rs2_read_enable_i && (sb.rs2_addr_i != '0) && r_pending[sb.rs2_addr_i] &&
                     !(sb.ld_wb_valid_i && (sb.ld_wb_addr_i == sb.rs2_addr_i));
  assign w_load    = sb.issue_valid_i && sb.issue_is_load_i;
  assign w_waw     = w_load && (sb.issue_rd_addr_i != '0) && r_pending[sb.issue_rd_addr_i] &&
                     !(sb.ld_wb_valid_i && (sb.ld_wb_addr_i == sb.issue_rd_addr_i));
  assign w_full    = w_load && (r_cnt == CW'(MAX_PENDING)) && !sb.ld_wb_valid_i;
  assign w_stall   = w_rs1_haz || w_rs2_haz || w_waw || w_full;
  assign w_acc     = w_load && !w_stall && !sb.flush_i && (sb.issue_rd_addr_i != '0);

  assign sb.stall_req_o   = w_stall;
  assign sb.pending_cnt_o = r_cnt;

  // Clear before set so a same-cycle write-back and new load to one register leaves it pending.
  always_comb begin
    w_pending_nxt = r_pending;
    if (sb.ld_wb_valid_i) w_pending_nxt[sb.ld_wb_addr_i] = 1'b0;
    if (w_acc)            w_pending_nxt[sb.issue_rd_addr_i] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_acc && !sb.ld_wb_valid_i)                      w_cnt_nxt = r_cnt + CW'(1);
    else if (!w_acc && sb.ld_wb_valid_i && (r_cnt != '0)) w_cnt_nxt = r_cnt - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_cnt     <= '0;
    end else if (sb.flush_i) begin
      r_pending <= '0;
      r_cnt     <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

`ifdef SCOREBOARD_WATCHDOG_EN
  localparam int WW = $clog2(STALL_TIMEOUT + 1);

  logic [WW-1:0] r_wd_cnt;
  logic [WW-1:0] w_wd_nxt;
  logic          r_timeout;

  always_comb begin
    w_wd_nxt = '0;
    if (w_stall) w_wd_nxt = (r_wd_cnt == WW'(STALL_TIMEOUT)) ? r_wd_cnt : r_wd_cnt + WW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wd_cnt  <= w_wd_nxt;
      r_timeout <= r_timeout || (w_wd_nxt == WW'(STALL_TIMEOUT));
    end
  end

  assign sb.timeout_o = r_timeout;
`else
  assign sb.timeout_o = 1'b0;
`endif
endmodule
